// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - shared opcodes, ALU codes, control bundle layout and decode helpers
package id_pkg;

    localparam int CTRL_W = 13;

    typedef enum logic [3:0] {
        OP_NOP  = 4'b0000,
        OP_ST   = 4'b0011,
        OP_ADD  = 4'b0100,
        OP_INC  = 4'b0101,
        OP_NEG  = 4'b0110,
        OP_SUB  = 4'b0111,
        OP_J    = 4'b1000,
        OP_BRZ  = 4'b1001,
        OP_JM   = 4'b1010,
        OP_BRN  = 4'b1011,
        OP_LD   = 4'b1110,
        OP_SVPC = 4'b1111
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_NEG   = 3'b010,
        ALU_ADDPC = 3'b011,
        ALU_PASS  = 3'b100
    } aluop_e;

    // Bit 0 is ALUSrc, bits 3:1 ALUOp, then MemRead .. JumpM upward to bit 12.
    typedef struct packed {
        logic   jumpm;
        logic   jump;
        logic   regwrite;
        logic   memtoreg;
        logic   branchz;
        logic   branchn;
        logic   pc_control;
        logic   memwrite;
        logic   memread;
        aluop_e aluop;
        logic   alusrc;
    } ctrl_t;

    // Undefined opcodes fall through to an all-zero (NOP) bundle.
    function automatic ctrl_t decode_ctrl(input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_SVPC: begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.aluop = ALU_ADDPC; end
            OP_LD:   begin c.memread = 1'b1; c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            OP_ST:   c.memwrite = 1'b1;
            OP_ADD:  begin c.regwrite = 1'b1; c.aluop = ALU_ADD; end
            OP_INC:  begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.aluop = ALU_ADD; end
            OP_NEG:  begin c.regwrite = 1'b1; c.aluop = ALU_NEG; end
            OP_SUB:  begin c.regwrite = 1'b1; c.aluop = ALU_SUB; end
            OP_J:    begin c.jump = 1'b1; c.pc_control = 1'b1; end
            OP_BRZ:  begin c.branchz = 1'b1; c.pc_control = 1'b1; end
            OP_JM:   begin c.jumpm = 1'b1; c.memread = 1'b1; c.pc_control = 1'b1; end
            OP_BRN:  begin c.branchn = 1'b1; c.pc_control = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic op_uses_rs(input logic [3:0] op);
        case (op)
            OP_ST, OP_ADD, OP_INC, OP_NEG, OP_SUB,
            OP_J, OP_BRZ, OP_JM, OP_BRN, OP_LD: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic op_uses_rt(input logic [3:0] op);
        case (op)
            OP_ST, OP_ADD, OP_SUB: return 1'b1;
            default:               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_p_if.sv
// rtl/id_stage_p_if.sv - IF->ID instruction handshake and ID/EX output bundle
// Signals:
//   in_valid, instr_in, pc_in : instruction offered by IF
//   stall_out                 : ID asks IF to hold
//   out_valid .. pc_out       : registered ID/EX boundary
interface id_stage_p_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 6
);
    logic                      in_valid;
    logic [31:0]               instr_in;
    logic [XLEN-1:0]           pc_in;
    logic                      stall_out;
    logic                      out_valid;
    logic [id_pkg::CTRL_W-1:0] ctrl_out;
    logic [XLEN-1:0]           rs_val;
    logic [XLEN-1:0]           rt_val;
    logic [XLEN-1:0]           imm_out;
    logic [RA_W-1:0]           rd_out;
    logic [XLEN-1:0]           pc_out;

    modport master (
        output in_valid, instr_in, pc_in,
        input  stall_out, out_valid, ctrl_out, rs_val, rt_val, imm_out, rd_out, pc_out
    );

    modport slave (
        input  in_valid, instr_in, pc_in,
        output stall_out, out_valid, ctrl_out, rs_val, rt_val, imm_out, rd_out, pc_out
    );
endinterface

// File: rtl/regfile_p.sv
// rtl/regfile_p.sv - register file with one write port, two combinational read ports and WB bypass
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (clears every entry)
//   we, waddr, wdata  : write port, commits on the rising edge
//   raddr_a, raddr_b  : read addresses
//   rdata_a, rdata_b  : read data, bypassed from the write port on an address match
module regfile_p #(
    parameter int XLEN     = 32,
    parameter int RA_W     = 6,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [RA_W-1:0] waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [RA_W-1:0] raddr_a,
    input  logic [RA_W-1:0] raddr_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b
);
    localparam int DEPTH = 2 ** RA_W;

    logic [XLEN-1:0] mem_q [DEPTH];
    logic            w_zero;
    logic            a_zero;
    logic            b_zero;

    assign w_zero = (ZERO_REG != 0) && (waddr == '0);
    assign a_zero = (ZERO_REG != 0) && (raddr_a == '0);
    assign b_zero = (ZERO_REG != 0) && (raddr_b == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && !w_zero) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Zero-register check comes first so a WB aimed at x0 never leaks through the bypass.
    assign rdata_a = a_zero                   ? '0    :
                     (we && waddr == raddr_a) ? wdata : mem_q[raddr_a];
    assign rdata_b = b_zero                   ? '0    :
                     (we && waddr == raddr_b) ? wdata : mem_q[raddr_b];

endmodule

// File: rtl/id_stage_p.sv
// rtl/id_stage_p.sv - instruction decode stage: register read, decode, load-use stall, ID/EX register
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   id (slave)                  : instruction in, stall_out, registered ID/EX outputs
//   wb_we, wb_rd, wb_data       : writeback port into the register file
//   ex_valid, ex_memread, ex_rd : instruction currently in EX, for load-use detection
//   flush                       : kill the instruction in ID
module id_stage_p
    import id_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RA_W     = 6,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    id_stage_p_if.slave     id,
    input  logic            wb_we,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_valid,
    input  logic            ex_memread,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            flush
);
    logic [3:0]      opcode;
    logic [RA_W-1:0] rd_a;
    logic [RA_W-1:0] rs_a;
    logic [RA_W-1:0] rt_a;
    logic [XLEN-1:0] rs_rd;
    logic [XLEN-1:0] rt_rd;
    logic [XLEN-1:0] imm_ext;
    ctrl_t           dec;
    logic            rs_hit;
    logic            rt_hit;
    logic            hazard;
    logic            unused_instr_bits;

    logic            valid_q, valid_d;
    ctrl_t           ctrl_q,  ctrl_d;
    logic [XLEN-1:0] rs_q,    rs_d;
    logic [XLEN-1:0] rt_q,    rt_d;
    logic [XLEN-1:0] imm_q,   imm_d;
    logic [RA_W-1:0] rd_q,    rd_d;
    logic [XLEN-1:0] pc_q,    pc_d;

    assign opcode  = id.instr_in[31:28];
    assign rd_a    = RA_W'(id.instr_in[27:22]);
    assign rs_a    = RA_W'(id.instr_in[21:16]);
    assign rt_a    = RA_W'(id.instr_in[15:10]);
    assign imm_ext = {{(XLEN-6){id.instr_in[15]}}, id.instr_in[15:10]};
    assign dec     = decode_ctrl(opcode);

    assign unused_instr_bits = ^id.instr_in[9:0];

    regfile_p #(
        .XLEN     (XLEN),
        .RA_W     (RA_W),
        .ZERO_REG (ZERO_REG)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wb_we),
        .waddr   (wb_rd),
        .wdata   (wb_data),
        .raddr_a (rs_a),
        .raddr_b (rt_a),
        .rdata_a (rs_rd),
        .rdata_b (rt_rd)
    );

    // x0 can never be produced by a load when ZERO_REG is set, so it never stalls.
    assign rs_hit = op_uses_rs(opcode) && (ex_rd == rs_a) && !((ZERO_REG != 0) && (rs_a == '0));
    assign rt_hit = op_uses_rt(opcode) && (ex_rd == rt_a) && !((ZERO_REG != 0) && (rt_a == '0));
    assign hazard = id.in_valid && ex_valid && ex_memread && (rs_hit || rt_hit);

    // A flushed instruction is being discarded anyway, so holding IF would only lose a cycle.
    assign id.stall_out = hazard && !flush;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        imm_d   = imm_q;
        rd_d    = rd_q;
        pc_d    = pc_q;
        if (flush || hazard) begin
            // Bubble: data fields keep their previous contents.
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else begin
            valid_d = id.in_valid;
            ctrl_d  = id.in_valid ? dec : '0;
            rs_d    = rs_rd;
            rt_d    = rt_rd;
            imm_d   = imm_ext;
            rd_d    = rd_a;
            pc_d    = id.pc_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            imm_q   <= imm_d;
            rd_q    <= rd_d;
            pc_q    <= pc_d;
        end
    end

    assign id.out_valid = valid_q;
    assign id.ctrl_out  = ctrl_q;
    assign id.rs_val    = rs_q;
    assign id.rt_val    = rt_q;
    assign id.imm_out   = imm_q;
    assign id.rd_out    = rd_q;
    assign id.pc_out    = pc_q;

endmodule

// File: doc/id_stage_p.md
Name: id_stage_p

Overview:
- Parametrised instruction-decode stage for the pipelined SCU-ISA CPU. Sits between IF and EX.
- Contains the register file, with a WB write port and write-before-read bypass.
- Contains the opcode-to-control decoder and load-use hazard detection.
- Drives a registered ID/EX pipeline boundary with a valid bit, bubble insertion and flush.

Parameters:
- XLEN, 32, data and PC width.
- RA_W, 6, register-address width; the register file has 2**RA_W entries.
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instr_in/pc_in hold a valid instruction.
- instr_in  in  32  instruction; fields: opcode[31:28], rd[27:22], rs[21:16], rt[15:10].
- pc_in  in  XLEN  PC of instr_in.
- wb_we  in  1  writeback enable.
- wb_rd  in  RA_W  writeback register address.
- wb_data  in  XLEN  writeback data.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_memread  in  1  EX instruction is a load.
- ex_rd  in  RA_W  EX instruction destination register.
- flush  in  1  branch/jump taken; kill the instruction in ID.
- stall_out  out  1  combinational; IF must hold the PC and instr_in.
- out_valid  out  1  ID/EX holds a valid instruction.
- ctrl_out  out  CTRL_W  registered control bundle (fields listed under Decomposition).
- rs_val  out  XLEN  registered rs operand.
- rt_val  out  XLEN  registered rt operand.
- imm_out  out  XLEN  registered sign-extended instr[15:10].
- rd_out  out  RA_W  registered destination register.
- pc_out  out  XLEN  registered PC.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registered outputs go to 0.
  - All register-file entries go to 0.
  - stall_out follows its combinational equation and reads 0 while in_valid=0.
- Latency: 1 cycle. An instruction accepted at edge n appears on the outputs after edge n.
- Register file:
  - Writes occur on the rising edge when wb_we=1.
  - When ZERO_REG=1 and wb_rd=0, the write is dropped.
  - Read ports are combinational.
  - Same-cycle bypass: if wb_we=1 and wb_rd matches a read address (and that address is not register 0 with ZERO_REG=1), the read returns wb_data.
- Decode by opcode. Any control not listed for an opcode is 0.
  - NOP 0000: none.
  - SVPC 1111: RegWrite, ALUSrc, ALUOp=ADDPC.
  - LD 1110: MemRead, MemtoReg, RegWrite.
  - ST 0011: MemWrite.
  - ADD 0100: RegWrite, ALUOp=ADD.
  - INC 0101: RegWrite, ALUSrc, ALUOp=ADD.
  - NEG 0110: RegWrite, ALUOp=NEG.
  - SUB 0111: RegWrite, ALUOp=SUB.
  - J 1000: Jump, PC_Control.
  - BRZ 1001: BranchZ, PC_Control.
  - JM 1010: JumpM, MemRead, PC_Control.
  - BRN 1011: BranchN, PC_Control.
  - Undefined opcodes decode as NOP, with out_valid still 1.
- Operand use:
  - rs is used by every opcode except NOP and SVPC.
  - rt is used by ADD, SUB and ST.
- Hazard detection:
  - hazard = in_valid & ex_valid & ex_memread & ((uses_rs & ex_rd==rs) | (uses_rt & ex_rd==rt)).
  - A match on register 0 with ZERO_REG=1 is not a hazard.
  - stall_out = hazard & ~flush.
- Pipeline register update on each edge, in priority order:
  1. flush=1: out_valid<=0 and ctrl_out<=0; data fields are don't-care but are held.
  2. hazard: a bubble is inserted (out_valid<=0, ctrl_out<=0). The instruction remains at the inputs because IF is stalled.
  3. Otherwise: out_valid<=in_valid. ctrl_out<=decoded value when in_valid=1, else 0. Operands, imm, rd and pc are captured.
- Simultaneous flush and hazard: flush wins and stall_out=0.
- A stall lasts exactly one cycle per load-use pair, because the load leaves EX on the next edge.
- wb_we and a hazard in the same cycle are independent: the write still commits.
- Reset asserted mid-stall clears out_valid and drops any pending bubble.

Decomposition:
- Shared package id_pkg holds:
  - Opcode constants.
  - ALUOp codes: ADD=000, SUB=001, NEG=010, ADDPC=011, PASS=100.
  - The ctrl bundle field indices, in order: ALUSrc, ALUOp[2:0], MemRead, MemWrite, PC_Control, BranchN, BranchZ, MemtoReg, RegWrite, Jump, JumpM.
  - CTRL_W = 13.
- One sub-module: regfile_p, holding the register storage, write port and bypass logic.

Test Plan:
- Reset release: all outputs 0. Write x2=1 and x1=5 via WB, then issue ADD x3,x2,x1 (instr 0x40C20400) → next cycle out_valid=1, rs_val=1, rt_val=5, rd_out=3, RegWrite=1, ALUOp=000.
- Bypass: wb_we=1, wb_rd=2, wb_data=0xDEAD in the same cycle ADD x3,x2,x1 is in ID → rs_val=0xDEAD.
- Load-use: ex_valid=1, ex_memread=1, ex_rd=2 with ADD reading x2 → stall_out=1 for one cycle, bubble (out_valid=0, ctrl=0). Next cycle with ex_memread=0 → ADD issues.
- Flush and hazard together: flush=1 and hazard=1 → stall_out=0, next out_valid=0.
- ZERO_REG: WB writes 0x55 to x0, then ADD reads x0 → rs_val=0. A load to ex_rd=0 causes no stall.
- INC x4,x4,-1 (rt field 111111) → imm_out=0xFFFFFFFF, ALUSrc=1. Asserting rst_n low mid-instruction → all outputs 0 immediately.
